// File: rtl/md_e.sv
// Execute-stage multiply/divide unit. It sits beside the ALU and shares its
// forwarded operands. HI/LO update a fixed number of cycles after an
// operation is accepted, and Busy is high for exactly that many cycles.
module md_e #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [2:0]  MDop,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        state;
    md_op_t        op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [CW-1:0] cnt;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   dvd;
    logic [31:0]   dvs;
    logic [31:0]   quo;
    logic [31:0]   rem;
    logic [31:0]   quo_s;
    logic [31:0]   rem_s;
    logic [63:0]   res;
    logic          res_wr;

    // Result of the latched operation. The signed divide runs on operand
    // magnitudes through the same unsigned divider used by divu, and the
    // signs are fixed up afterwards. A zero divisor suppresses the write.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        mag_a  = a_q[31] ? (32'd0 - a_q) : a_q;
        mag_b  = b_q[31] ? (32'd0 - b_q) : b_q;
        dvd    = (op_q == OP_DIV) ? mag_a : a_q;
        dvs    = (op_q == OP_DIV) ? mag_b : b_q;
        quo    = '0;
        rem    = '0;
        if (dvs != 32'd0) begin
            quo = dvd / dvs;
            rem = dvd % dvs;
        end
        quo_s  = (a_q[31] ^ b_q[31]) ? (32'd0 - quo) : quo;
        rem_s  = a_q[31] ? (32'd0 - rem) : rem;
        res    = '0;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT: begin
                res    = prod_s;
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res    = prod_u;
                res_wr = 1'b1;
            end
            OP_DIV: begin
                res    = {rem_s, quo_s};
                res_wr = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res    = {rem, quo};
                res_wr = (b_q != 32'd0);
            end
            default: begin
                res    = '0;
                res_wr = 1'b0;
            end
        endcase
    end

    // Control FSM: accept operations while idle, count down the latency,
    // then commit HI/LO and drop Busy on the final edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    case (md_op_t'(MDop))
                        OP_MULT, OP_MULTU: begin
                            op_q  <= md_op_t'(MDop);
                            a_q   <= SrcA;
                            b_q   <= SrcB;
                            cnt   <= CW'(MULT_CYCLES);
                            state <= S_BUSY;
                            Busy  <= 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_q  <= md_op_t'(MDop);
                            a_q   <= SrcA;
                            b_q   <= SrcB;
                            cnt   <= CW'(DIV_CYCLES);
                            state <= S_BUSY;
                            Busy  <= 1'b1;
                        end
                        OP_MTHI: HI <= SrcA;
                        OP_MTLO: LO <= SrcA;
                        default: ;
                    endcase
                end
                S_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        if (res_wr) begin
                            HI <= res[63:32];
                            LO <= res[31:0];
                        end
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
